// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with valid/ready handshakes, carry, zero and signed-overflow flags.
// Shifts iterate one bit per cycle; define ALU_PIPE_BARREL_EN for a single-cycle barrel shifter instead.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  // state | meaning
  // IDLE  | accepting input; single-cycle ops resolve on the accept edge
  // SHIFT | iterative shift in progress, input blocked

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  logic [SHW-1:0]   amt;
  logic             accept;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] c_res;
  logic             c_cout;
  logic             c_ovf;

  assign amt    = b[SHW-1:0];
  assign accept = in_valid && in_ready;
  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

`ifdef ALU_PIPE_BARREL_EN
  // Extra bit below/above the operand catches the last bit shifted out (0 when amt=0).
  logic [WIDTH:0] shr_ext;
  logic [WIDTH:0] shl_ext;
  assign shr_ext = {a, 1'b0} >> amt;
  assign shl_ext = {1'b0, a} << amt;
`endif

  always_comb begin
    c_res  = '0;
    c_cout = 1'b0;
    c_ovf  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        c_res  = sum[WIDTH-1:0];
        c_cout = sum[WIDTH];
        c_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: c_res = a & b;
      OP_OR:  c_res = a | b;
      OP_XOR: c_res = a ^ b;
`ifdef ALU_PIPE_BARREL_EN
      OP_SHR: begin
        c_res  = shr_ext[WIDTH:1];
        c_cout = shr_ext[0];
      end
      OP_SHL: begin
        c_res  = shl_ext[WIDTH-1:0];
        c_cout = shl_ext[WIDTH];
      end
`else
      // Only amt=0 shifts resolve here; longer shifts go through SHIFT.
      OP_SHR, OP_SHL: c_res = a;
`endif
      OP_NOT: c_res = ~a;
      default: c_res = '0;
    endcase
  end

`ifdef ALU_PIPE_BARREL_EN
  assign in_ready = !rst && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        result    <= c_res;
        cout      <= c_cout;
        zero      <= (c_res == '0);
        ovf       <= c_ovf;
        out_valid <= 1'b1;
      end
    end
  end
`else
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] work;
  logic             dir_right;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] work_next;
  logic             shift_bit;
  logic             go_iter;

  assign in_ready  = !rst && (state == IDLE) && (!out_valid || out_ready);
  assign go_iter   = ((op == OP_SHR) || (op == OP_SHL)) && (amt != '0);
  assign work_next = dir_right ? (work >> 1) : (work << 1);
  assign shift_bit = dir_right ? work[0] : work[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      work      <= '0;
      dir_right <= 1'b0;
      cnt       <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (go_iter) begin
              work      <= a;
              dir_right <= (op == OP_SHR);
              cnt       <= amt;
              state     <= SHIFT;
            end else begin
              result    <= c_res;
              cout      <= c_cout;
              zero      <= (c_res == '0);
              ovf       <= c_ovf;
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt - SHW'(1);
          // Last shift step also publishes, giving amt+1 cycles of latency.
          if (cnt == SHW'(1)) begin
            result    <= work_next;
            cout      <= shift_bit;
            zero      <= (work_next == '0);
            ovf       <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe at WIDTH=8 against a scoreboard model,
// plus an exhaustive opcode/operand sweep at WIDTH=4.
module tb_alu_pipe;

`ifdef ALU_PIPE_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  typedef struct {
    int unsigned res;
    bit          c;
    bit          z;
    bit          v;
  } exp_t;

  typedef struct {
    exp_t e;
    int   acc;
    int   lat;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, cout, zero, ovf;
  logic [7:0] a, b, result;
  logic [2:0] op;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, cout4, zero4, ovf4;
  logic [3:0] a4, b4, result4;
  logic [2:0] op4;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    rand_rdy = 1'b0;
  bit    held = 1'b0;
  int    first_cyc = 0;
  item_t sb_q[$];

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout), .zero(zero), .ovf(ovf)
  );

  alu_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4), .op(op4),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4), .cout(cout4), .zero(zero4), .ovf(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rand_rdy) out_ready = (($urandom % 4) != 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(int w, int o, int unsigned x, int unsigned y);
    exp_t        e;
    int unsigned mask;
    int unsigned full;
    int          half, sx, sy, sv, amt;
    mask = (32'd1 << w) - 1;
    half = 1 << (w - 1);
    sx   = (x >= half) ? int'(x) - 2 * half : int'(x);
    sy   = (y >= half) ? int'(y) - 2 * half : int'(y);
    amt  = int'(y) % w;
    e.res = 0; e.c = 0; e.v = 0;
    case (o)
      0: begin
        full  = x + y;
        e.res = full & mask;
        e.c   = ((full >> w) & 1) != 0;
        sv    = sx + sy;
        e.v   = (sv >= half) || (sv < -half);
      end
      1: begin
        full  = x + (~y & mask) + 1;
        e.res = full & mask;
        e.c   = ((full >> w) & 1) != 0;
        sv    = sx - sy;
        e.v   = (sv >= half) || (sv < -half);
      end
      2: e.res = x & y;
      3: e.res = x | y;
      4: e.res = x ^ y;
      5: begin
        e.res = (x >> amt) & mask;
        e.c   = (amt != 0) && (((x >> (amt - 1)) & 1) != 0);
      end
      6: begin
        e.res = (x << amt) & mask;
        e.c   = (amt != 0) && (((x >> (w - amt)) & 1) != 0);
      end
      default: e.res = ~x & mask;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  function automatic int exp_lat(int w, int o, int unsigned y);
    int amt;
    amt = int'(y) % w;
    if (BARREL || !(o == 5 || o == 6) || amt == 0) return 1;
    return amt + 1;
  endfunction

  // Scoreboard for the 8-bit instance: push on accept, pop and compare on output transfer.
  always @(negedge clk) begin : mon
    item_t it;
    if (rst) begin
      sb_q.delete();
      held = 1'b0;
    end else begin
      if (out_valid) begin
        if (!held) first_cyc = cyc;
        if (out_ready) begin
          check("queue nonempty at output", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            it = sb_q.pop_front();
            check("sb result", result, it.e.res);
            check("sb cout", cout, it.e.c);
            check("sb zero", zero, it.e.z);
            check("sb ovf", ovf, it.e.v);
            check("sb latency", first_cyc - it.acc, it.lat);
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
        end
      end else begin
        held = 1'b0;
      end
      if (in_valid && in_ready) begin
        it.e   = model(8, int'(op), a, b);
        it.acc = cyc;
        it.lat = exp_lat(8, int'(op), b);
        sb_q.push_back(it);
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int n;
    n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send accept timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a  = 8'($urandom);
    b  = 8'($urandom);
    op = 3'($urandom);
  endtask

  task automatic dir(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] r, input bit c, input bit z, input bit v);
    int n;
    n = 0;
    send(o, x, y);
    check({tag, " in_ready after accept"}, in_ready, exp_lat(8, int'(o), y) == 1);
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n + 1, exp_lat(8, int'(o), y));
    check({tag, " result"}, result, r);
    check({tag, " cout"}, cout, c);
    check({tag, " zero"}, zero, z);
    check({tag, " ovf"}, ovf, v);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain timeout", n < 200, 1);
  endtask

  task automatic run4(input int o, input int x, input int y);
    exp_t e;
    int   n, lat;
    string t;
    e = model(4, o, x, y);
    t = $sformatf("w4 op%0d a%0h b%0h", o, x, y);
    n = 0;
    op4 = 3'(o); a4 = 4'(x); b4 = 4'(y); in_valid4 = 1'b1;
    @(negedge clk);
    while (!in_ready4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready4) check({t, " accept timeout"}, in_ready4, 1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 1;
    while (!out_valid4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({t, " latency"}, lat, exp_lat(4, o, y));
    check({t, " result"}, result4, e.res);
    check({t, " cout"}, cout4, e.c);
    check({t, " zero"}, zero4, e.z);
    check({t, " ovf"}, ovf4, e.v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; op4 = '0; out_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset flags", {cout, zero, ovf}, 0);
    check("in_ready during reset", in_ready, 0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", in_ready, 1);

    dir("add ff+01", 3'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
    dir("sub 80-01", 3'd1, 8'h80, 8'h01, 8'h7F, 1, 0, 1);
    dir("sub 05-07", 3'd1, 8'h05, 8'h07, 8'hFE, 0, 0, 0);
    dir("add 7f+01", 3'd0, 8'h7F, 8'h01, 8'h80, 0, 0, 1);
    dir("shl c1<<2", 3'd6, 8'hC1, 8'h02, 8'h04, 1, 0, 0);
    dir("shr 81>>0", 3'd5, 8'h81, 8'h00, 8'h81, 0, 0, 0);
    dir("shr 80>>7", 3'd5, 8'h80, 8'h07, 8'h01, 0, 0, 0);
    dir("shl 03<<7", 3'd6, 8'h03, 8'h07, 8'h80, 1, 0, 0);
    dir("not ff", 3'd7, 8'hFF, 8'h12, 8'h00, 0, 1, 0);
    drain();

    t0 = cyc;
    for (int i = 0; i < 4; i++) send(3'd0, 8'(i * 17), 8'(i + 3));
    check("b2b accept cycles", cyc - t0, 4);
    drain();

    out_ready = 1'b0;
    send(3'd2, 8'hF3, 8'h3C);
    op = 3'd4; a = 8'h55; b = 8'h0F; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold out_valid", out_valid, 1);
      check("hold result", result, 8'h30);
      check("hold flags", {cout, zero, ovf}, 0);
      check("hold in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain+accept in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("drain+accept out_valid", out_valid, 1);
    check("drain+accept result", result, 8'h5A);
    drain();

    send(3'd5, 8'hF0, 8'h07);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid-shift rst in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid-shift rst out_valid", out_valid, 0);
    check("mid-shift rst result", result, 0);
    check("mid-shift rst cout", cout, 0);
    #1;
    check("mid-shift rst in_ready after", in_ready, 1);
    dir("and after rst", 3'd2, 8'h3C, 8'h0F, 8'h0C, 0, 0, 0);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 3) == 0) begin
        @(posedge clk); #1;
      end
      send(3'($urandom), 8'($urandom), 8'($urandom));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    for (int o = 0; o < 8; o++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          run4(o, x, y);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
